// File: rtl/mvau_wstrm_pkg.sv
// Shared types and constants for the MVAU weight streamer.
package mvau_wstrm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } wstrm_state_t;

  localparam int unsigned WSTRM_FIFO_DEPTH = 2;
  localparam int unsigned WSTRM_STAT_BW    = 32;

endpackage

// File: rtl/mvau_wstrm_fifo.sv
// Output buffer for the weight streamer: push/occupancy on the input side,
// valid/ready on the output side. The head word is held until it is popped.
module mvau_wstrm_fifo
  import mvau_wstrm_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic                                       aclk,
  input  logic                                       aresetn,
  input  logic                                       push,
  input  logic [W-1:0]                               din,
  output logic [$clog2(WSTRM_FIFO_DEPTH+1)-1:0]      occ,
  output logic                                       out_v,
  input  logic                                       out_rdy,
  output logic [W-1:0]                               dout
);

  localparam int unsigned PTR_BW = $clog2(WSTRM_FIFO_DEPTH);
  localparam int unsigned OCC_BW = $clog2(WSTRM_FIFO_DEPTH + 1);

  logic [W-1:0]      mem [WSTRM_FIFO_DEPTH];
  logic [PTR_BW-1:0] rd_ptr;
  logic [PTR_BW-1:0] wr_ptr;
  logic              pop;

  assign out_v = (occ != '0);
  assign pop   = out_v & out_rdy;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < WSTRM_FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PTR_BW'(WSTRM_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_BW'(WSTRM_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_BW'(1);
        2'b01:   occ <= occ - OCC_BW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/mvau_weight_streamer.sv
// Sweeps the MVAU weight memory NUM_REPS times per start and streams words out.
// Define MVAU_WSTRM_STATS_EN to add the stall_cnt backpressure counter port.
module mvau_weight_streamer
  import mvau_wstrm_pkg::*;
#(
  parameter int unsigned SIMD         = 2,
  parameter int unsigned TW           = 1,
  parameter int unsigned WMEM_DEPTH   = 4,
  parameter int unsigned WMEM_ADDR_BW = 4,
  parameter int unsigned NUM_REPS     = 4,
  parameter int unsigned REP_BW       = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [WMEM_ADDR_BW-1:0]  wmem_addr,
  input  logic [SIMD*TW-1:0]       wmem_out,
  output logic                     out_v,
  input  logic                     out_rdy,
  output logic [SIMD*TW-1:0]       out_wgt
`ifdef MVAU_WSTRM_STATS_EN
  ,
  output logic [WSTRM_STAT_BW-1:0] stall_cnt
`endif
);

  localparam int unsigned OCC_BW = $clog2(WSTRM_FIFO_DEPTH + 1);
  localparam int unsigned CR_BW  = OCC_BW + 1;

  wstrm_state_t            state_q;
  logic [WMEM_ADDR_BW-1:0] addr_q;
  logic [REP_BW-1:0]       rep_q;
  logic                    inflight_q;
  logic                    busy_q;
  logic                    done_q;
  logic [OCC_BW-1:0]       occ;
  logic                    pop;
  logic                    issue;
  logic                    last_issue;
  logic                    last_pop;

  assign wmem_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pop       = out_v & out_rdy;

  // Words in the FIFO plus the read still in the memory pipeline must fit
  // in the FIFO after this cycle's pop, so read data is never dropped.
  always_comb begin
    issue      = 1'b0;
    last_issue = 1'b0;
    last_pop   = 1'b0;
    if (state_q == RUN)
      issue = (CR_BW'(occ) + CR_BW'(inflight_q)) < (CR_BW'(WSTRM_FIFO_DEPTH) + CR_BW'(pop));
    last_issue = issue && (addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1))
                       && (rep_q == REP_BW'(NUM_REPS - 1));
    last_pop   = (state_q == DRAIN) && pop && (occ == OCC_BW'(1)) && !inflight_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rep_q      <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            rep_q   <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1)) begin
              addr_q <= '0;
              rep_q  <= rep_q + 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          if (last_issue) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_pop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mvau_wstrm_fifo #(
    .W (SIMD * TW)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (inflight_q),
    .din     (wmem_out),
    .occ     (occ),
    .out_v   (out_v),
    .out_rdy (out_rdy),
    .dout    (out_wgt)
  );

`ifdef MVAU_WSTRM_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (out_v && !out_rdy && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/mvau_weight_streamer.md
# mvau_weight_streamer

Sequencer that sits directly upstream of the per-PE MVAU weight memory. It drives `wmem_addr`, absorbs the memory's one-cycle registered read latency, and presents weight words to the PE datapath over a valid/ready stream. Each `start` runs the streamer through the memory `NUM_REPS` times, one sweep per output pixel, with no bubbles while the consumer is ready.

## Interface
- `SIMD`, default 2: input lanes per PE.
- `TW`, default 1: weight bit width.
- `WMEM_DEPTH`, default 4: words per memory sweep. Must be at least 2.
- `WMEM_ADDR_BW`, default 4: address width. Must satisfy clog2(WMEM_DEPTH) ≤ WMEM_ADDR_BW.
- `NUM_REPS`, default 4: sweeps per `start`. Must be at least 1.
- `REP_BW`, default 8: repetition counter width.
- `aclk`, in, 1: the block's single clock.
- `aresetn`, in, 1: reset. Asynchronous, active-low.
- `start`, in, 1: begin a job. Sampled only in IDLE.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse when the job completes.
- `wmem_addr`, out, WMEM_ADDR_BW: read address to the weight memory.
- `wmem_out`, in, SIMD*TW: weight memory read data. Valid one cycle after an address is issued.
- `out_v`, out, 1: output weight valid.
- `out_rdy`, in, 1: consumer ready.
- `out_wgt`, out, SIMD*TW: output weight word.

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
- IDLE → RUN when `start`=1 is sampled.
- RUN → DRAIN at the edge where the last read of the job is issued (address WMEM_DEPTH-1 with rep = NUM_REPS-1).
- DRAIN → IDLE at the edge where the final word is handshaked. `done` pulses in the following cycle.
- A read is "issued" in a cycle when the FSM is in RUN and credit is available. The memory captures `wmem_addr` at the end of that cycle.
- The address counter increments on each issue. It wraps from WMEM_DEPTH-1 to 0 and increments rep on the wrap.
- Read data is pushed into a 2-entry output FIFO. `out_v` is high whenever the FIFO is not empty. `out_wgt` is the FIFO head.
- Credit rule: issue only when FIFO occupancy + in-flight reads − (pop this cycle) < 2. The FIFO therefore never overflows. `wmem_out` is never dropped and never captured twice.
- A handshake occurs when `out_v` and `out_rdy` are both high. That cycle pops the FIFO.
- A simultaneous push and pop leaves the occupancy unchanged.
- `start` is ignored outside IDLE.
- `out_v`, once raised, stays high with `out_wgt` stable until the handshake.
- Counter arithmetic is unsigned. The total word count per job is WMEM_DEPTH*NUM_REPS exactly.
- Reset, including assertion mid-job, forces the following immediately:
  - state IDLE;
  - `wmem_addr`=0;
  - `out_v`=0, `out_wgt`=0;
  - `busy`=0, `done`=0;
  - FIFO empty;
  - counters 0.
  - Any in-flight read is discarded.

## Timing
- Take edge E0 as the edge that samples `start`.
- Address 0 is driven from the cycle after E0. The memory captures it at E1. The data is pushed at E2, and `out_v` rises after E2.
- First-word latency from start sampled to `out_v` is therefore 2 cycles.
- With `out_rdy` held at 1, throughput is 1 word per cycle. `busy` then stays high for WMEM_DEPTH*NUM_REPS + 2 cycles.
- After `out_rdy` deasserts, at most 2 words are buffered and issuing stalls. When `out_rdy` reasserts, the stream resumes with no lost cycles.
- `done` rises in the cycle after the final handshake. `busy` falls in that same cycle.

## Configuration
- `MVAU_WSTRM_STATS_EN` defined: the block adds an output port `stall_cnt` (32 bits, unsigned).
  - It counts cycles with `out_v`=1 and `out_rdy`=0.
  - It clears when `start` is accepted and saturates at all-ones.
  - Reset value is 0.
- `MVAU_WSTRM_STATS_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `mvau_wstrm_pkg`:
  - the state enum `wstrm_state_t` (IDLE/RUN/DRAIN);
  - the FIFO depth constant `WSTRM_FIFO_DEPTH`=2;
  - the stats counter width `WSTRM_STAT_BW`=32.
- One sub-module, `mvau_wstrm_fifo`: a 2-entry FIFO with valid/ready on its output and push/occupancy on its input.
- The top module contains the FSM, the address and rep counters, credit logic and the optional stats counter.

## Test plan
- Reset values: drive `aresetn`=0 → `wmem_addr`=0, `out_v`=0, `out_wgt`=0, `busy`=0, `done`=0.
- Full-rate job: memory model with 1-cycle latency; WMEM_DEPTH=4, NUM_REPS=2, memory = {0x1,0x2,0x3,0x0}; `out_rdy`=1.
  - Words 1,2,3,0,1,2,3,0 appear on consecutive cycles.
  - The first word is valid 2 cycles after `start`.
  - `done` pulses once, 10 cycles after `start`.
- Backpressure: same job; `out_rdy` toggles 1,0,0,1 repeating.
  - The 8 words arrive in order, with no loss and no duplicates.
  - `out_wgt` is stable while stalled.
  - With `MVAU_WSTRM_STATS_EN` defined, `stall_cnt` equals the number of stalled cycles.
- Start while busy: pulse `start` again mid-job → ignored. Exactly 8 words are produced and `done` pulses once.
- Mid-job reset: assert `aresetn`=0 after 3 handshakes.
  - All outputs return to reset values immediately.
  - A new `start` reproduces the full sequence from address 0.
- NUM_REPS=1, WMEM_DEPTH=2 with `out_rdy`=0 until FIFO full: exactly 2 words are buffered and `wmem_addr` holds. Releasing `out_rdy` delivers both words, then `done`.
